// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_pkg
//   Shared definitions for the UART transmit buffer: character width, default
//   FIFO geometry and the drain-FSM state encoding.
//
//   Drain state encoding (2 bits):
//     DRAIN_IDLE  = 2'd0
//     DRAIN_START = 2'd1
//     DRAIN_WAIT  = 2'd2
//     2'd3 is never produced. If it is ever seen, it is decoded as IDLE.
// ---------------------------------------------------------------------------
package uart_tx_fifo_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int FIFO_DEPTH_DEF  = 16;
  localparam int FIFO_ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_START = 2'd1,
    DRAIN_WAIT  = 2'd2
  } drain_state_e;

  // The unused encoding is treated as IDLE, so it does not report busy.
  function automatic logic drain_busy(input drain_state_e s);
    return (s == DRAIN_START) || (s == DRAIN_WAIT);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
//   Circular byte FIFO for the UART transmit path. It holds the storage array,
//   the read/write pointers, the occupancy count, full/empty and the sticky
//   overflow flag. The occupancy count is the only source of full and empty.
//
// Ports
//   clk_i       system clock
//   reset_i     synchronous, active-high; clears pointers, count and overflow
//   wr_en_i     push strobe; ignored (and flagged) when full
//   wr_data_i   byte to push
//   rd_en_i     pop strobe; ignored when empty
//   rd_data_o   byte at the head of the FIFO (combinational)
//   full_o      count == DEPTH
//   empty_o     count == 0
//   count_o     bytes currently held
//   overflow_o  sticky: a push was dropped while full
//   ovf_clr_i   clears overflow_o (a same-edge drop wins)
// ---------------------------------------------------------------------------
module uart_sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_en_i,
  input  logic [UART_DATA_W-1:0] wr_data_i,
  input  logic                   rd_en_i,
  output logic [UART_DATA_W-1:0] rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [ADDR_W:0]        count_o,
  output logic                   overflow_o,
  input  logic                   ovf_clr_i
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              overflow_q, overflow_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // full/empty come from the registered count, so a push on the same edge as
  // a pop from a full FIFO is still rejected.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = wr_en_i & ~full;
  assign pop   = rd_en_i & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wr_en_i && full) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit buffer and launcher that sits directly upstream of uart_tx. The
//   host pushes bytes into a circular FIFO. The drain FSM pops one byte,
//   presents it on tx_data_o and pulses tx_start_o for one cycle. It then
//   waits for tx_done_i before it launches the next byte.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   DRAIN_IDLE  | no frame in flight; pops and launches when FIFO non-empty
//   DRAIN_START | tx_start_o is high for this one cycle
//   DRAIN_WAIT  | frame in flight; leaves on tx_done_i (no timeout)
//
// Ports
//   clk_i       system clock
//   reset_i     synchronous, active-high; discards queued bytes, aborts FSM
//   wr_en_i     host write strobe, one byte per cycle
//   wr_data_i   host byte
//   full_o      FIFO holds DEPTH bytes
//   empty_o     FIFO holds no bytes
//   count_o     bytes held (the byte being transmitted is not counted)
//   overflow_o  sticky: a write was dropped while full
//   ovf_clr_i   clears overflow_o
//   busy_o      drain FSM not idle
//   tx_start_o  one-cycle launch pulse to uart_tx
//   tx_data_o   byte to uart_tx, stable from tx_start_o until tx_done_i
//   tx_done_i   one-cycle completion pulse from uart_tx
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_en_i,
  input  logic [UART_DATA_W-1:0] wr_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [ADDR_W:0]        count_o,
  output logic                   overflow_o,
  input  logic                   ovf_clr_i,
  output logic                   busy_o,
  output logic                   tx_start_o,
  output logic [UART_DATA_W-1:0] tx_data_o,
  input  logic                   tx_done_i
);

  drain_state_e           state_q,    state_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_DATA_W-1:0] tx_data_q,  tx_data_d;

  logic                   pop;
  logic [UART_DATA_W-1:0] head_data;
  logic                   fifo_empty;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .rd_en_i    (pop),
    .rd_data_o  (head_data),
    .full_o     (full_o),
    .empty_o    (fifo_empty),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .ovf_clr_i  (ovf_clr_i)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= DRAIN_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;

    case (state_q)
      DRAIN_START: begin
        state_d = DRAIN_WAIT;
      end
      DRAIN_WAIT: begin
        if (tx_done_i) begin
          state_d = DRAIN_IDLE;
        end
      end
      default: begin
        // DRAIN_IDLE, and the unused encoding behaves the same way. tx_done_i
        // is deliberately not looked at here.
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_data_d  = head_data;
          tx_start_d = 1'b1;
          state_d    = DRAIN_START;
        end
      end
    endcase
  end

  assign empty_o    = fifo_empty;
  assign busy_o     = drain_busy(state_q);
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              wr_en_i;
  logic [7:0]        wr_data_i;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   count_o;
  logic              overflow_o;
  logic              ovf_clr_i;
  logic              busy_o;
  logic              tx_start_o;
  logic [7:0]        tx_data_o;
  logic              tx_done_i;

  int total = 0;
  int bad   = 0;

  // reference model state (updated on posedge from the driven inputs only)
  int         mcount = 0;
  int         mstate = 0;   // 0 idle, 1 start, 2 wait
  bit         movf   = 0;
  bit         mstart = 0;
  bit         m_acc;
  bit         m_pop;
  logic [7:0] sb[$];        // bytes accepted and not yet launched, in order
  logic [7:0] last_tx = 8'h00;
  int         n_start = 0;
  bit         chk_en  = 0;
  bit         auto_en = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .ovf_clr_i  (ovf_clr_i),
    .busy_o     (busy_o),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .tx_done_i  (tx_done_i)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change right after a negedge; the routine returns at the next one.
  task automatic step(input bit we, input logic [7:0] d, input bit clr);
    wr_en_i   = we;
    wr_data_i = d;
    ovf_clr_i = clr;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int bound, input string name);
    int k = 0;
    while (!(sb.size() == 0 && mstate == 0 && mcount == 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= bound) begin
      bad++;
      $display("FAIL %s: not drained after %0d cycles, queued=%0d model_count=%0d", name, k, sb.size(), mcount);
    end
  endtask

  // Behavioural model of the buffer, including the scoreboard push.
  initial begin
    forever begin
      @(posedge clk);
      if (reset_i) begin
        mcount  = 0;
        mstate  = 0;
        movf    = 0;
        mstart  = 0;
        sb.delete();
        last_tx = 8'h00;
      end else begin
        m_acc  = wr_en_i && (mcount < DEPTH);
        m_pop  = 0;
        mstart = 0;
        if (wr_en_i && mcount == DEPTH) movf = 1;
        else if (ovf_clr_i)             movf = 0;
        case (mstate)
          0: if (mcount > 0) begin m_pop = 1; mstart = 1; mstate = 1; end
          1: mstate = 2;
          default: if (tx_done_i) mstate = 0;
        endcase
        mcount = mcount + int'(m_acc) - int'(m_pop);
        if (m_acc) sb.push_back(wr_data_i);
      end
    end
  end

  // uart_tx stand-in plus per-cycle output checks and scoreboard pop.
  initial begin
    bit         pend = 0;
    int         dly  = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (auto_en) begin
        tx_done_i = 1'b0;
        if (pend) begin
          if (dly == 0) begin tx_done_i = 1'b1; pend = 0; end
          else dly--;
        end
      end
      if (chk_en) begin
        if (tx_start_o === 1'b1) begin
          n_start++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_pop: tx_start with data %0h but nothing expected at t=%0t", tx_data_o, $time);
          end else begin
            e       = sb.pop_front();
            last_tx = e;
          end
          if (auto_en) begin pend = 1; dly = $urandom_range(0, 4); end
        end
        chk("tx_data", tx_data_o, last_tx);
        chk("count", count_o, mcount);
        chk("empty", empty_o, mcount == 0);
        chk("full", full_o, mcount == DEPTH);
        chk("busy", busy_o, mstate != 0);
        chk("tx_start", tx_start_o, mstart);
        chk("overflow", overflow_o, movf);
      end
    end
  end

  typedef struct {
    bit         we;
    logic [7:0] d;
    bit         done;
    logic [4:0] cnt;
    bit         busy;
    bit         start;
  } vec_t;

  vec_t tv[13];
  int   s0;

  initial begin
    // single byte, spurious done in idle, write on the same edge as a pop,
    // and the two-cycle gap from tx_done to the next tx_start
    tv[0]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1};
    tv[2]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 8'h01, 1'b0, 5'd1, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 8'h02, 1'b0, 5'd1, 1'b1, 1'b1};
    tv[8]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0};
    tv[10] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1};
    tv[11] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0};
    tv[12] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0};

    reset_i   = 1'b1;
    wr_en_i   = 1'b0;
    wr_data_i = 8'h00;
    ovf_clr_i = 1'b0;
    tx_done_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    chk_en  = 1;

    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tx_start", tx_start_o, 0);
    chk("rst_tx_data", tx_data_o, 8'h00);

    for (int i = 0; i < 13; i++) begin
      tx_done_i = tv[i].done;
      step(tv[i].we, tv[i].d, 1'b0);
      chk($sformatf("vec%0d_count", i), count_o, tv[i].cnt);
      chk($sformatf("vec%0d_empty", i), empty_o, tv[i].cnt == 0);
      chk($sformatf("vec%0d_busy", i), busy_o, tv[i].busy);
      chk($sformatf("vec%0d_start", i), tx_start_o, tv[i].start);
    end
    tx_done_i = 1'b0;
    step(1'b0, 8'h00, 1'b0);

    // burst 01..05 with a responding transmitter
    auto_en = 1;
    s0 = n_start;
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    wait_drain(400, "burst_drain");
    chk("burst_starts", n_start - s0, 5);

    // fill while the transmitter is stalled, then overflow handling
    auto_en   = 0;
    tx_done_i = 1'b0;
    reset_i   = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    reset_i = 1'b0;
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    chk("fill_full", full_o, 1);
    chk("fill_count", count_o, 16);
    chk("fill_ovf", overflow_o, 0);
    step(1'b1, 8'hFF, 1'b0);
    chk("drop_ovf", overflow_o, 1);
    chk("drop_count", count_o, 16);
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_clr", overflow_o, 0);
    step(1'b1, 8'hFE, 1'b1);
    chk("ovf_set_wins", overflow_o, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_clr2", overflow_o, 0);
    tx_done_i = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    tx_done_i = 1'b0;
    step(1'b1, 8'hEE, 1'b0);
    chk("fullpop_count", count_o, 15);
    chk("fullpop_ovf", overflow_o, 1);
    chk("fullpop_start", tx_start_o, 1);
    step(1'b0, 8'h00, 1'b0);
    tx_done_i = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    tx_done_i = 1'b0;
    auto_en   = 1;
    wait_drain(800, "fill_drain");
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_final_clr", overflow_o, 0);

    // reset with a frame in flight and three bytes queued
    auto_en   = 0;
    tx_done_i = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h31 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", count_o, 3);
    chk("pre_rst_busy", busy_o, 1);
    reset_i = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    reset_i = 1'b0;
    chk("midrst_start", tx_start_o, 0);
    chk("midrst_empty", empty_o, 1);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_count", count_o, 0);
    s0 = n_start;
    repeat (10) step(1'b0, 8'h00, 1'b0);
    chk("midrst_no_start", n_start - s0, 0);

    // spurious tx_done while idle and empty
    tx_done_i = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    tx_done_i = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("spur_busy", busy_o, 0);
    chk("spur_start", tx_start_o, 0);
    chk("spur_starts", n_start - s0, 0);

    // normal operation resumes after the reset
    auto_en = 1;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    wait_drain(200, "final_drain");
    chk("final_starts", n_start - s0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
